frac_feeder: RTL and testbench

FRAC_FEEDER -- requirements
Module: frac_feeder

---
 rtl/frac_pkg.sv | 28 ++
 rtl/frac_row_buf.sv | 36 +++
 rtl/frac_feeder.sv | 133 +++++++++++++
 tb/tb_frac_feeder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frac_pkg.sv
// Shared constants, FSM encoding and the org-window helper for the fractional
// search feeder.
package frac_pkg;

  localparam int PIX_W       = 8;
  localparam int PIX_PER_ROW = 8;
  localparam int ROWS        = 8;
  localparam int ROW_W       = PIX_W * PIX_PER_ROW;
  localparam int ROW_AW      = 3;
  localparam int CNT_W       = 3;
  localparam int RES_WAIT    = 2;
  localparam int ORG_HI      = 55;
  localparam int ORG_LO      = 8;
  localparam int ORG_W       = ORG_HI - ORG_LO + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // The search engine only consumes the six interior pixels of an org row.
  function automatic logic [ORG_W-1:0] org_window(input logic [ROW_W-1:0] row);
    return row[ORG_HI:ORG_LO];
  endfunction

endpackage

// File: rtl/frac_row_buf.sv
// CUR and ORG row buffers: one shared write port, one combinational read port
// per buffer, cleared by synchronous reset.
module frac_row_buf
  import frac_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ROW_AW-1:0] wr_row,
  input  logic [ROW_W-1:0]  wr_data,
  input  logic [ROW_AW-1:0] cur_rd_row,
  output logic [ROW_W-1:0]  cur_rd_data,
  input  logic [ROW_AW-1:0] org_rd_row,
  output logic [ORG_W-1:0]  org_rd_win
);

  logic [ROW_W-1:0] cur_mem [ROWS];
  logic [ROW_W-1:0] org_mem [ROWS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) begin
        cur_mem[r] <= '0;
        org_mem[r] <= '0;
      end
    end else if (wr_en) begin
      if (wr_sel) org_mem[wr_row] <= wr_data;
      else        cur_mem[wr_row] <= wr_data;
    end
  end

  assign cur_rd_data = cur_mem[cur_rd_row];
  assign org_rd_win  = org_window(org_mem[org_rd_row]);

endmodule

// File: rtl/frac_feeder.sv
// Streams an 8-row CUR/ORG block to the fractional search engine and captures
// its motion vector. Define FRAC_FEEDER_SAD_EN to also capture the SAD result.
module frac_feeder
  import frac_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ROW_AW-1:0] wr_row,
  input  logic [ROW_W-1:0]  wr_data,
  input  logic              start,
  output logic              busy,
  output logic              wr_drop,
  output logic              ready,
  output logic [ROW_W-1:0]  cur_pix,
  output logic [ORG_W-1:0]  org_pix,
  input  logic [2:0]        mvx_in,
  input  logic [2:0]        mvy_in,
  output logic              mv_valid,
  output logic [2:0]        mvx,
  output logic [2:0]        mvy
`ifdef FRAC_FEEDER_SAD_EN
  ,
  input  logic [11:0]       sad_in,
  output logic [11:0]       sad_out
`endif
);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [ROW_AW-1:0] org_rd_row;
  logic [ROW_W-1:0]  cur_rd_data;
  logic [ORG_W-1:0]  org_rd_win;
  logic              feed_next;
  logic              org_live;
  logic              capture;

  frac_row_buf u_buf (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en & ~busy),
    .wr_sel      (wr_sel),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .cur_rd_row  (cnt_next),
    .cur_rd_data (cur_rd_data),
    .org_rd_row  (org_rd_row),
    .org_rd_win  (org_rd_win)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FEED;
          cnt_next   = '0;
        end
      end
      ST_FEED: begin
        if (cnt == CNT_W'(ROWS - 1)) begin
          state_next = ST_WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_W'(RES_WAIT - 1)) begin
          state_next = ST_DONE;
          cnt_next   = '0;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the FSM.
  always_comb begin
    feed_next  = (state_next == ST_FEED);
    org_rd_row = cnt_next - 1'b1;
    org_live   = (cnt_next >= CNT_W'(2));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ready    <= 1'b0;
      cur_pix  <= '0;
      org_pix  <= '0;
      mv_valid <= 1'b0;
      mvx      <= '0;
      mvy      <= '0;
      wr_drop  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      ready    <= feed_next;
      cur_pix  <= feed_next ? cur_rd_data : '0;
      org_pix  <= (feed_next && org_live) ? org_rd_win : '0;
      mv_valid <= (state_next == ST_DONE);
      busy     <= (state_next != ST_IDLE);
      wr_drop  <= wr_en & busy;
      if (capture) begin
        mvx <= mvx_in;
        mvy <= mvy_in;
      end
    end
  end

`ifdef FRAC_FEEDER_SAD_EN
  always_ff @(posedge clk) begin
    if (reset)        sad_out <= '0;
    else if (capture) sad_out <= sad_in;
  end
`endif

endmodule

// File: tb/tb_frac_feeder.sv
// Directed self-checking bench for frac_feeder; honours FRAC_FEEDER_SAD_EN.
module tb_frac_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic        wr_sel;
  logic [2:0]  wr_row;
  logic [63:0] wr_data;
  logic        start;
  logic        busy;
  logic        wr_drop;
  logic        ready;
  logic [63:0] cur_pix;
  logic [47:0] org_pix;
  logic [2:0]  mvx_in;
  logic [2:0]  mvy_in;
  logic        mv_valid;
  logic [2:0]  mvx;
  logic [2:0]  mvy;
`ifdef FRAC_FEEDER_SAD_EN
  logic [11:0] sad_in;
  logic [11:0] sad_out;
`endif

  int total = 0;
  int bad   = 0;

  logic [63:0] cur_m [8];
  logic [63:0] org_m [8];

  frac_feeder dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_row   (wr_row),
    .wr_data  (wr_data),
    .start    (start),
    .busy     (busy),
    .wr_drop  (wr_drop),
    .ready    (ready),
    .cur_pix  (cur_pix),
    .org_pix  (org_pix),
    .mvx_in   (mvx_in),
    .mvy_in   (mvy_in),
    .mv_valid (mv_valid),
    .mvx      (mvx),
    .mvy      (mvy)
`ifdef FRAC_FEEDER_SAD_EN
    ,
    .sad_in   (sad_in),
    .sad_out  (sad_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one cycle of write/start inputs, then returns them to idle.
  task automatic applyStimulus(input logic en, input logic sel, input logic [2:0] row,
                               input logic [63:0] data, input logic st);
    wr_en   = en;
    wr_sel  = sel;
    wr_row  = row;
    wr_data = data;
    start   = st;
    @(negedge clk);
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  // Runs one block transfer and checks it against the buffer model.
  task automatic runTransfer(input string tag, input bit do_drop, input bit do_restart,
                             input logic [2:0] ex_mvx, input logic [2:0] ex_mvy);
    int          lat;
    int          pulses;
    int          stray_ready;
    bit          seen;
    logic [63:0] org_row;
    logic [47:0] org_exp;
    applyStimulus(1'b0, 1'b0, 3'd0, 64'd0, 1'b1);
    lat = 2;
    for (int i = 0; i < 8; i++) begin
      org_row = (i >= 2) ? org_m[i-1] : 64'd0;
      org_exp = org_row[55:8];
      checkOutput($sformatf("%s_ready%0d", tag, i), {63'd0, ready}, 64'd1);
      checkOutput($sformatf("%s_busy%0d", tag, i), {63'd0, busy}, 64'd1);
      checkOutput($sformatf("%s_cur%0d", tag, i), cur_pix, cur_m[i]);
      checkOutput($sformatf("%s_org%0d", tag, i), {16'd0, org_pix}, {16'd0, org_exp});
      if (do_drop && i == 4) begin
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_row  = 3'd3;
        wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      if (do_drop && i == 5)
        checkOutput({tag, "_wr_drop"}, {63'd0, wr_drop}, 64'd1);
      @(negedge clk);
      wr_en = 1'b0;
      lat++;
    end
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s_wait_ready%0d", tag, i), {63'd0, ready}, 64'd0);
      checkOutput($sformatf("%s_wait_cur%0d", tag, i), cur_pix, 64'd0);
      checkOutput($sformatf("%s_wait_org%0d", tag, i), {16'd0, org_pix}, 64'd0);
      checkOutput($sformatf("%s_wait_mv%0d", tag, i), {63'd0, mv_valid}, 64'd0);
      if (do_restart && i == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      if (mv_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    checkOutput({tag, "_mv_seen"}, {63'd0, seen}, 64'd1);
    checkOutput({tag, "_latency"}, 64'(lat), 64'd12);
    checkOutput({tag, "_mvx"}, {61'd0, mvx}, {61'd0, ex_mvx});
    checkOutput({tag, "_mvy"}, {61'd0, mvy}, {61'd0, ex_mvy});
    checkOutput({tag, "_done_busy"}, {63'd0, busy}, 64'd1);
`ifdef FRAC_FEEDER_SAD_EN
    checkOutput({tag, "_sad"}, {52'd0, sad_out}, {52'd0, sad_in});
`endif
    if (do_restart) begin
      wr_en   = 1'b1;
      wr_sel  = 1'b0;
      wr_row  = 3'd0;
      wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    end
    mvx_in = ~ex_mvx;
    mvy_in = ~ex_mvy;
    @(negedge clk);
    wr_en = 1'b0;
    checkOutput({tag, "_mv_pulse_end"}, {63'd0, mv_valid}, 64'd0);
    checkOutput({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    checkOutput({tag, "_mvx_hold"}, {61'd0, mvx}, {61'd0, ex_mvx});
    checkOutput({tag, "_mvy_hold"}, {61'd0, mvy}, {61'd0, ex_mvy});
    if (do_restart) begin
      checkOutput({tag, "_done_wr_drop"}, {63'd0, wr_drop}, 64'd1);
      pulses = 0;
      stray_ready = 0;
      for (int k = 0; k < 14; k++) begin
        @(negedge clk);
        if (mv_valid) pulses++;
        if (ready) stray_ready++;
      end
      checkOutput({tag, "_extra_mv"}, 64'(pulses), 64'd0);
      checkOutput({tag, "_extra_ready"}, 64'(stray_ready), 64'd0);
    end
  endtask

  initial begin
    int pulses;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_row  = 3'd0;
    wr_data = 64'd0;
    start   = 1'b0;
    mvx_in  = 3'd0;
    mvy_in  = 3'd0;
`ifdef FRAC_FEEDER_SAD_EN
    sad_in  = 12'd0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {63'd0, ready}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_mv_valid", {63'd0, mv_valid}, 64'd0);
    checkOutput("rst_mvx", {61'd0, mvx}, 64'd0);
    checkOutput("rst_wr_drop", {63'd0, wr_drop}, 64'd0);
    checkOutput("rst_cur", cur_pix, 64'd0);
    reset = 1'b0;

    for (int r = 0; r < 8; r++) begin
      cur_m[r] = 64'h1111_1111_1111_1111 * 64'(r + 1);
      org_m[r] = 64'h0101_0101_0101_0101 * 64'(r + 16);
      applyStimulus(1'b1, 1'b0, 3'(r), cur_m[r], 1'b0);
      applyStimulus(1'b1, 1'b1, 3'(r), org_m[r], 1'b0);
    end
    checkOutput("idle_wr_drop", {63'd0, wr_drop}, 64'd0);

    $display("[TB] basic transfer");
    mvx_in = 3'd5;
    mvy_in = 3'd2;
`ifdef FRAC_FEEDER_SAD_EN
    sad_in = 12'd1234;
`endif
    runTransfer("basic", 1'b0, 1'b0, 3'd5, 3'd2);

    $display("[TB] write while busy");
    mvx_in = 3'd1;
    mvy_in = 3'd7;
    runTransfer("drop", 1'b1, 1'b0, 3'd1, 3'd7);

    $display("[TB] start while busy");
    mvx_in = 3'd4;
    mvy_in = 3'd3;
    runTransfer("restart", 1'b0, 1'b1, 3'd4, 3'd3);

    $display("[TB] reset mid-feed");
    applyStimulus(1'b0, 1'b0, 3'd0, 64'd0, 1'b1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", {63'd0, ready}, 64'd0);
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_cur", cur_pix, 64'd0);
    checkOutput("abort_mvx", {61'd0, mvx}, 64'd0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'd0, 64'h5555_5555_5555_5555, 1'b1);
    reset = 1'b0;
    checkOutput("rst_start_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_wr_drop2", {63'd0, wr_drop}, 64'd0);
    pulses = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (mv_valid || ready) pulses++;
    end
    checkOutput("abort_no_mv", 64'(pulses), 64'd0);
    for (int r = 0; r < 8; r++) begin
      cur_m[r] = 64'd0;
      org_m[r] = 64'd0;
    end
    mvx_in = 3'd3;
    mvy_in = 3'd6;
`ifdef FRAC_FEEDER_SAD_EN
    sad_in = 12'd77;
`endif
    runTransfer("zero", 1'b0, 1'b0, 3'd3, 3'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
